// File: rtl/pll_reconfig_ctrl_pkg.sv
// Shared types for the PLL reconfiguration sequencer in CLOCK_MGMT.
package pll_reconfig_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    WAIT_DONE,
    WAIT_LOCK,
    FAIL,
    OK
  } pll_ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DONE_TO = 2'd1,
    ERR_LOCK_TO = 2'd2
  } pll_ctrl_err_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Request handshake between LTPI link/speed logic and the PLL reconfig sequencer.
interface pll_reconfig_ctrl_if #(
  parameter int unsigned CFG_W = 3
);
  logic             req_valid;
  logic [CFG_W-1:0] req_cfg;
  logic             req_ready;

  modport master (output req_valid, output req_cfg, input req_ready);
  modport slave  (input req_valid, input req_cfg, output req_ready);
endinterface

// File: rtl/pll_lock_sync.sv
// Synchronizes raw PLL lock into mgmt_clk, qualifies it as stable and flags lock loss.
module pll_lock_sync #(
  parameter int unsigned LOCK_STABLE = 16
) (
  input  logic mgmt_clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic in_idle,
  input  logic clear,
  output logic stable,
  output logic lock_lost
);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

  logic          meta;
  logic          lock_s;
  logic [SW-1:0] cnt;

  assign stable = (cnt == SW'(LOCK_STABLE));

  always_ff @(posedge mgmt_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta      <= 1'b0;
      lock_s    <= 1'b0;
      cnt       <= '0;
      lock_lost <= 1'b0;
    end else begin
      meta      <= pll_locked;
      lock_s    <= meta;
      // A low lock_s also clears the counter, so this fires only once per drop.
      lock_lost <= in_idle && stable && !lock_s;
      if (clear || !lock_s) cnt <= '0;
      else if (!stable)     cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequences m10_pll_top reconfiguration: load config, pulse reconfig, wait for
// done and stable lock, retry on timeout, report ok/err.
module pll_reconfig_ctrl
  import pll_reconfig_ctrl_pkg::*;
#(
  parameter int unsigned CFG_W        = 3,
  parameter int unsigned DEFAULT_CFG  = 0,
  parameter int unsigned DONE_TIMEOUT = 1023,
  parameter int unsigned LOCK_TIMEOUT = 4095,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic               mgmt_clk,
  input  logic               reset_n,
  pll_reconfig_ctrl_if.slave req,
  output logic [CFG_W-1:0]   pll_configuration,
  output logic               pll_reconfig,
  input  logic               pll_configuration_done,
  input  logic               pll_locked,
  output logic [CFG_W-1:0]   cur_cfg,
  output logic               busy,
  output logic               cfg_ok,
  output logic               cfg_err,
  output logic [1:0]         err_code,
  output logic               lock_lost
);
  localparam int unsigned TMAX = max_u(DONE_TIMEOUT, LOCK_TIMEOUT);
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned AW   = $clog2(MAX_RETRY + 2);

  pll_ctrl_state_t  state, next;
  pll_ctrl_err_t    fail_code;
  logic [CFG_W-1:0] cfg_q;
  logic [TW-1:0]    timer;
  logic [AW-1:0]    attempt;
  logic             stable;
  logic             clr_stable;

  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .mgmt_clk   (mgmt_clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .in_idle    (state == IDLE),
    .clear      (clr_stable),
    .stable     (stable),
    .lock_lost  (lock_lost)
  );

  assign req.req_ready = ~busy;

  always_comb begin
    next       = state;
    clr_stable = 1'b0;
    unique case (state)
      IDLE:      if (req.req_valid)
                   next = (req.req_cfg == cur_cfg && stable) ? OK : LOAD;
      LOAD:      next = PULSE;
      PULSE:     next = WAIT_DONE;
      // done has priority over a coincident timeout
      WAIT_DONE: if (pll_configuration_done) begin
                   next       = WAIT_LOCK;
                   clr_stable = 1'b1;
                 end else if (timer == TW'(DONE_TIMEOUT)) next = FAIL;
      WAIT_LOCK: if (stable) next = OK;
                 else if (timer == TW'(LOCK_TIMEOUT)) next = FAIL;
      FAIL:      next = (attempt < AW'(MAX_RETRY)) ? LOAD : IDLE;
      OK:        next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge mgmt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cfg_q             <= CFG_W'(DEFAULT_CFG);
      pll_configuration <= CFG_W'(DEFAULT_CFG);
      cur_cfg           <= CFG_W'(DEFAULT_CFG);
      pll_reconfig      <= 1'b0;
      busy              <= 1'b0;
      cfg_ok            <= 1'b0;
      cfg_err           <= 1'b0;
      err_code          <= ERR_NONE;
      fail_code         <= ERR_NONE;
      timer             <= '0;
      attempt           <= '0;
    end else begin
      state        <= next;
      pll_reconfig <= (next == PULSE);
      busy         <= (next != IDLE);
      cfg_ok       <= (state == OK);
      cfg_err      <= (state == FAIL) && (next == IDLE);
      unique case (state)
        IDLE:      if (req.req_valid) begin
                     cfg_q    <= req.req_cfg;
                     attempt  <= '0;
                     err_code <= ERR_NONE;
                   end
        LOAD:      pll_configuration <= cfg_q;
        PULSE:     timer <= '0;
        WAIT_DONE: begin
                     if (pll_configuration_done) timer <= '0;
                     else if (timer != TW'(TMAX)) timer <= timer + 1'b1;
                     if (next == FAIL) fail_code <= ERR_DONE_TO;
                   end
        WAIT_LOCK: begin
                     if (timer != TW'(TMAX)) timer <= timer + 1'b1;
                     if (next == FAIL) fail_code <= ERR_LOCK_TO;
                   end
        FAIL:      if (next == LOAD) attempt  <= attempt + 1'b1;
                   else              err_code <= fail_code;
        OK:        cur_cfg <= cfg_q;
        default:   ;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: table of request transactions plus hand sequences.
module tb_pll_reconfig_ctrl;
  localparam int unsigned CFG_W   = 3;
  localparam int unsigned DONE_TO = 1023;
  localparam int unsigned LOCK_TO = 4095;
  localparam int unsigned STABLE  = 16;
  localparam int unsigned RETRY   = 2;

  logic mgmt_clk = 1'b0;
  logic reset_n;
  always #5 mgmt_clk = ~mgmt_clk;

  pll_reconfig_ctrl_if #(.CFG_W(CFG_W)) req_if ();

  logic [CFG_W-1:0] pll_configuration, cur_cfg;
  logic             pll_reconfig, pll_configuration_done, pll_locked;
  logic             busy, cfg_ok, cfg_err, lock_lost;
  logic [1:0]       err_code;

  logic model_en, m_done, m_lock, man_done, man_lock;
  int   m_done_en, m_done_dly, m_lock_en, m_lock_dly;

  assign pll_configuration_done = model_en ? m_done : man_done;
  assign pll_locked             = model_en ? m_lock : man_lock;

  pll_reconfig_ctrl #(
    .CFG_W(CFG_W), .DEFAULT_CFG(0), .DONE_TIMEOUT(DONE_TO),
    .LOCK_TIMEOUT(LOCK_TO), .LOCK_STABLE(STABLE), .MAX_RETRY(RETRY)
  ) dut (
    .mgmt_clk               (mgmt_clk),
    .reset_n                (reset_n),
    .req                    (req_if),
    .pll_configuration      (pll_configuration),
    .pll_reconfig           (pll_reconfig),
    .pll_configuration_done (pll_configuration_done),
    .pll_locked             (pll_locked),
    .cur_cfg                (cur_cfg),
    .busy                   (busy),
    .cfg_ok                 (cfg_ok),
    .cfg_err                (cfg_err),
    .err_code               (err_code),
    .lock_lost              (lock_lost)
  );

  // Event counters sampled on the active edge
  int cyc = 0, n_pulse = 0, n_ok = 0, n_errp = 0, n_ll = 0;
  int last_pcyc = 0, gap = 0, last_pcfg = 0;
  always @(posedge mgmt_clk) begin
    cyc <= cyc + 1;
    if (pll_reconfig) begin
      n_pulse   <= n_pulse + 1;
      last_pcfg <= int'(pll_configuration);
      gap       <= cyc - last_pcyc;
      last_pcyc <= cyc;
    end
    if (cfg_ok)    n_ok   <= n_ok + 1;
    if (cfg_err)   n_errp <= n_errp + 1;
    if (lock_lost) n_ll   <= n_ll + 1;
  end

  // PLL model: drops lock on a reconfig pulse, returns done and lock after delays
  initial begin
    m_done = 1'b0;
    m_lock = 1'b1;
    forever begin
      @(posedge mgmt_clk); #2;
      if (model_en && pll_reconfig) begin
        m_lock = 1'b0;
        if (m_done_en != 0) begin
          repeat (m_done_dly) @(posedge mgmt_clk);
          #2 m_done = 1'b1;
          @(posedge mgmt_clk);
          #2 m_done = 1'b0;
          if (m_lock_en != 0) begin
            repeat (m_lock_dly) @(posedge mgmt_clk);
            #2 m_lock = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mgmt_clk);
    #1;
  endtask

  typedef struct {
    int cfg;
    int done_en, done_dly, lock_en, lock_dly;
    int exp_pulses, exp_ok, exp_err, exp_cur, exp_gap;
  } vec_t;

  task automatic do_req(input vec_t v, input int idx);
    int k, p0, o0, e0;
    bit fin;
    m_done_en  = v.done_en;
    m_done_dly = v.done_dly;
    m_lock_en  = v.lock_en;
    m_lock_dly = v.lock_dly;
    k = 0;
    while (!req_if.req_ready && k < 50) begin step(); k++; end
    check($sformatf("v%0d_ready", idx), 32'(req_if.req_ready), 1);
    p0 = n_pulse; o0 = n_ok; e0 = n_errp;
    req_if.req_cfg   = 3'(v.cfg);
    req_if.req_valid = 1'b1;
    step();
    req_if.req_valid = 1'b0;
    fin = 1'b0; k = 0;
    while (!fin && k < 20000) begin
      step(); k++;
      fin = (n_ok != o0) || (n_errp != e0);
    end
    check($sformatf("v%0d_complete", idx), 32'(fin), 1);
    repeat (2) step();
    check($sformatf("v%0d_pulses", idx), n_pulse - p0, v.exp_pulses);
    check($sformatf("v%0d_ok", idx), n_ok - o0, v.exp_ok);
    check($sformatf("v%0d_errpulse", idx), n_errp - e0, (v.exp_err != 0) ? 1 : 0);
    check($sformatf("v%0d_err_code", idx), 32'(err_code), v.exp_err);
    check($sformatf("v%0d_cur_cfg", idx), 32'(cur_cfg), v.exp_cur);
    check($sformatf("v%0d_busy", idx), 32'(busy), 0);
    if (v.exp_pulses > 0) check($sformatf("v%0d_pulse_cfg", idx), last_pcfg, v.cfg);
    if (v.exp_gap > 0)    check($sformatf("v%0d_retry_gap", idx), gap, v.exp_gap);
  endtask

  vec_t tbl[8];
  vec_t post;

  initial begin : main
    int k, o0, p0, e0, l0, first_ll;
    bit got;

    //            cfg de dd le ld  pul ok err cur gap
    // Done-timeout retry spacing: PULSE + (DONE_TO+1) WAIT_DONE + FAIL + LOAD
    tbl[0] = '{3, 1, 5, 1, 20, 1, 1, 0, 3, 0};
    tbl[1] = '{3, 1, 5, 1, 20, 0, 1, 0, 3, 0};
    tbl[2] = '{6, 1, 1, 1, 0,  1, 1, 0, 6, 0};
    tbl[3] = '{5, 0, 0, 0, 0,  3, 0, 1, 6, DONE_TO + 4};
    tbl[4] = '{0, 1, 3, 1, 4,  1, 1, 0, 0, 0};
    tbl[5] = '{2, 1, 2, 0, 0,  3, 0, 2, 0, 0};
    tbl[6] = '{0, 1, 2, 1, 2,  1, 1, 0, 0, 0};
    tbl[7] = '{7, 1, 1, 1, 3,  1, 1, 0, 7, 0};

    reset_n = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_cfg   = '0;
    model_en = 1'b1;
    man_done = 1'b0;
    man_lock = 1'b1;
    m_done_en = 1; m_done_dly = 1; m_lock_en = 1; m_lock_dly = 1;
    repeat (3) @(posedge mgmt_clk);
    #1;
    check("rst_pll_configuration", 32'(pll_configuration), 0);
    check("rst_cur_cfg", 32'(cur_cfg), 0);
    check("rst_pll_reconfig", 32'(pll_reconfig), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_if.req_ready), 1);
    check("rst_cfg_ok", 32'(cfg_ok), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    reset_n = 1'b1;
    repeat (25) step();

    for (int i = 0; i < 8; i++) do_req(tbl[i], i);

    // Same-cfg fast path with req_valid held across busy
    repeat (3) step();
    o0 = n_ok; p0 = n_pulse;
    req_if.req_cfg = 3'd7;
    req_if.req_valid = 1'b1;
    step();
    check("fp_busy_t1", 32'(busy), 1);
    check("fp_ready_t1", 32'(req_if.req_ready), 0);
    check("fp_ok_t1", 32'(cfg_ok), 0);
    step();
    check("fp_ok_t2", 32'(cfg_ok), 1);
    check("fp_ready_t2", 32'(req_if.req_ready), 1);
    step();
    check("fp_reaccept_busy", 32'(busy), 1);
    req_if.req_valid = 1'b0;
    step();
    check("fp_ok_t4", 32'(cfg_ok), 1);
    repeat (3) step();
    check("fp_ok_count", n_ok - o0, 2);
    check("fp_no_pulse", n_pulse - p0, 0);

    // Full-path pulse timing against the accept cycle
    m_done_en = 1; m_done_dly = 2; m_lock_en = 1; m_lock_dly = 1;
    req_if.req_cfg = 3'd4;
    req_if.req_valid = 1'b1;
    step();
    req_if.req_valid = 1'b0;
    check("tm_busy_t1", 32'(busy), 1);
    check("tm_pulse_t1", 32'(pll_reconfig), 0);
    check("tm_cfg_t1", 32'(pll_configuration), 7);
    step();
    check("tm_pulse_t2", 32'(pll_reconfig), 1);
    check("tm_cfg_t2", 32'(pll_configuration), 4);
    step();
    check("tm_pulse_t3", 32'(pll_reconfig), 0);
    k = 0;
    while (!cfg_ok && k < 200) begin step(); k++; end
    check("tm_ok_seen", 32'(cfg_ok), 1);
    step();
    check("tm_cur_cfg", 32'(cur_cfg), 4);

    // Lock glitch: lock timeout, retry, then success
    man_lock = 1'b1;
    man_done = 1'b0;
    model_en = 1'b0;
    repeat (3) step();
    o0 = n_ok; p0 = n_pulse; e0 = n_errp;
    req_if.req_cfg = 3'd1;
    req_if.req_valid = 1'b1;
    step();
    req_if.req_valid = 1'b0;
    k = 0;
    while (!pll_reconfig && k < 10) begin step(); k++; end
    check("gl_pulse1", 32'(pll_reconfig), 1);
    man_lock = 1'b0;
    repeat (3) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      man_lock = 1'b1;
      for (int j = 0; j < 11 && !got; j++) begin
        if (j == 10) man_lock = 1'b0;
        step();
        if (pll_reconfig) got = 1'b1;
      end
    end
    check("gl_retry_pulse", 32'(got), 1);
    check("gl_no_ok_before_retry", n_ok - o0, 0);
    check("gl_no_err_before_retry", n_errp - e0, 0);
    check("gl_err_code_mid", 32'(err_code), 0);
    man_lock = 1'b0;
    repeat (3) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    man_lock = 1'b1;
    k = 0;
    do begin step(); k++; end while (!cfg_ok && k < 100);
    check("gl_lock_latency", k, STABLE + 4);
    repeat (2) step();
    check("gl_pulses", n_pulse - p0, 2);
    check("gl_ok_count", n_ok - o0, 1);
    check("gl_err_count", n_errp - e0, 0);
    check("gl_err_code", 32'(err_code), 0);
    check("gl_cur_cfg", 32'(cur_cfg), 1);

    // Lock loss while idle
    repeat (5) step();
    l0 = n_ll;
    first_ll = 0;
    man_lock = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (lock_lost && first_ll == 0) first_ll = i;
    end
    check("ll_delay", first_ll, 3);
    check("ll_count", n_ll - l0, 1);

    // Reset in WAIT_LOCK
    man_lock = 1'b1;
    repeat (25) step();
    req_if.req_cfg = 3'd2;
    req_if.req_valid = 1'b1;
    step();
    req_if.req_valid = 1'b0;
    k = 0;
    while (!pll_reconfig && k < 10) begin step(); k++; end
    man_lock = 1'b0;
    repeat (2) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    repeat (5) step();
    check("mr_busy_before", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    check("mr_pll_configuration", 32'(pll_configuration), 0);
    check("mr_cur_cfg", 32'(cur_cfg), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_req_ready", 32'(req_if.req_ready), 1);
    check("mr_pll_reconfig", 32'(pll_reconfig), 0);
    check("mr_err_code", 32'(err_code), 0);
    check("mr_cfg_ok", 32'(cfg_ok), 0);
    check("mr_cfg_err", 32'(cfg_err), 0);
    repeat (2) @(posedge mgmt_clk);
    #1 reset_n = 1'b1;
    model_en = 1'b1;
    repeat (3) step();
    post = '{5, 1, 4, 1, 6, 1, 1, 0, 5, 0};
    do_req(post, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
